// File: rtl/fifo_pong_arbiter.sv
// fifo_pong_arbiter: round-robin owner of the single enqueue port of a
// two-entry ping-pong FIFO. Bounds each producer's burst, tracks FIFO
// occupancy from enqueue/dequeue fires and flags dequeue-when-empty.

// Per-producer port gating: ready only while owning and the FIFO can accept.
module fifo_pong_arbiter_port (
    input  logic own_i,
    input  logic fifo_rdy_i,
    input  logic ena_i,
    output logic rdy_o,
    output logic fire_o
);
    // RDY is independent of ENA; an ENA without RDY is simply dropped
    assign rdy_o  = own_i & fifo_rdy_i;
    assign fire_o = ena_i & rdy_o;
endmodule

module fifo_pong_arbiter #(
    parameter int WIDTH     = 704,
    parameter int MAX_BURST = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in0_req,
    input  logic             in0_enq__ENA,
    input  logic [WIDTH-1:0] in0_enq_v,
    output logic             in0_enq__RDY,
    input  logic             in1_req,
    input  logic             in1_enq__ENA,
    input  logic [WIDTH-1:0] in1_enq_v,
    output logic             in1_enq__RDY,
    output logic             out_enq__ENA,
    output logic [WIDTH-1:0] out_enq_v,
    input  logic             out_enq__RDY,
    input  logic             deq_fire,
    output logic [1:0]       grant,
    output logic [1:0]       occupancy,
    output logic             deq_err
);
    localparam int NUM_PROD = 2;
    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] beat_q, beat_d;
    logic       last_q, last_d;
    logic [1:0] occ_q, occ_d;
    logic       deq_err_q, deq_err_d;

    logic [NUM_PROD-1:0] req, ena, own, rdy, fire;
    logic                any_fire;
    logic                cur;
    logic                req_cur, req_oth;
    logic                grant_end;

    assign req = {in1_req, in0_req};
    assign ena = {in1_enq__ENA, in0_enq__ENA};
    assign own = {state_q == OWN1, state_q == OWN0};

    for (genvar i = 0; i < NUM_PROD; i++) begin : g_port
        fifo_pong_arbiter_port u_port (
            .own_i      (own[i]),
            .fifo_rdy_i (out_enq__RDY),
            .ena_i      (ena[i]),
            .rdy_o      (rdy[i]),
            .fire_o     (fire[i])
        );
    end

    assign any_fire     = |fire;
    assign in0_enq__RDY = rdy[0];
    assign in1_enq__RDY = rdy[1];

    // FIFO side: payload muxed straight through, no added latency
    assign out_enq__ENA = any_fire;
    assign out_enq_v    = own[1] ? in1_enq_v : in0_enq_v;

    assign grant     = own;
    assign occupancy = occ_q;
    assign deq_err   = deq_err_q;

    // Owner selection, burst bounding and round-robin pointer
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        last_d    = last_q;
        grant_end = 1'b0;
        cur       = (state_q == OWN1);
        req_cur   = req[cur];
        req_oth   = req[~cur];
        case (state_q)
            IDLE: begin
                beat_d = '0;
                if (req[0] && req[1])
                    state_d = last_q ? OWN0 : OWN1;
                else if (req[0])
                    state_d = OWN0;
                else if (req[1])
                    state_d = OWN1;
            end
            OWN0, OWN1: begin
                // stalls produce no fire, so the beat count freezes
                grant_end = !req_cur || (any_fire && beat_q == LAST_BEAT);
                if (grant_end) begin
                    last_d = cur;
                    beat_d = '0;
                    if (req_oth)
                        state_d = cur ? OWN0 : OWN1;
                    else if (req_cur)
                        state_d = state_q;
                    else
                        state_d = IDLE;
                end else if (any_fire) begin
                    beat_d = beat_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Occupancy tracking and sticky dequeue-when-empty flag
    always_comb begin
        occ_d     = occ_q;
        deq_err_d = deq_err_q;
        if (deq_fire && occ_q == 2'd0)
            deq_err_d = 1'b1;
        if (any_fire && !deq_fire) begin
            if (occ_q != 2'd2)
                occ_d = occ_q + 2'd1;
        end else if (deq_fire && !any_fire) begin
            if (occ_q != 2'd0)
                occ_d = occ_q - 2'd1;
        end
    end

    // State registers; last resets to 1 so producer 0 wins the first tie
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            last_q    <= 1'b1;
            occ_q     <= '0;
            deq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            last_q    <= last_d;
            occ_q     <= occ_d;
            deq_err_q <= deq_err_d;
        end
    end
endmodule

// File: tb/tb_fifo_pong_arbiter.sv
// Randomized and directed bench for fifo_pong_arbiter against a
// transaction-level model (owner id, beats delivered, FIFO entry count).
module tb_fifo_pong_arbiter;
    localparam int W  = 704;
    localparam int MB = 4;

    logic         CLK = 1'b0;
    logic         RST;
    logic         in0_req, in0_enq__ENA, in0_enq__RDY;
    logic         in1_req, in1_enq__ENA, in1_enq__RDY;
    logic [W-1:0] in0_enq_v, in1_enq_v, out_enq_v;
    logic         out_enq__ENA, out_enq__RDY, deq_fire, deq_err;
    logic [1:0]   grant, occupancy;

    int total = 0;
    int bad   = 0;

    // model: owner -1 = nobody
    int m_owner, m_beats, m_last, m_occ;
    bit m_err;

    fifo_pong_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
        .CLK(CLK), .RST(RST),
        .in0_req(in0_req), .in0_enq__ENA(in0_enq__ENA), .in0_enq_v(in0_enq_v), .in0_enq__RDY(in0_enq__RDY),
        .in1_req(in1_req), .in1_enq__ENA(in1_enq__ENA), .in1_enq_v(in1_enq_v), .in1_enq__RDY(in1_enq__RDY),
        .out_enq__ENA(out_enq__ENA), .out_enq_v(out_enq_v), .out_enq__RDY(out_enq__RDY),
        .deq_fire(deq_fire), .grant(grant), .occupancy(occupancy), .deq_err(deq_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_wide();
        logic [W-1:0] r;
        for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_beats = 0; m_last = 1; m_occ = 0; m_err = 0;
    endtask

    // One clock: drive inputs, check combinational view against model, advance
    task automatic cyc(input bit rst, input bit r0, input bit r1, input bit e0, input bit e1,
                       input bit frdy, input bit dq, input bit force_dq);
        bit fr, d, rdy0, rdy1, f0, f1, enq, rq_me, rq_ot;
        int me;
        logic [1:0] eg;
        fr = frdy && (m_occ < 2);
        d  = force_dq ? dq : (dq && m_occ > 0);
        RST = rst; in0_req = r0; in1_req = r1;
        in0_enq__ENA = e0; in1_enq__ENA = e1;
        in0_enq_v = rnd_wide(); in1_enq_v = rnd_wide();
        out_enq__RDY = fr; deq_fire = d;
        #1;
        eg   = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
        rdy0 = (m_owner == 0) && fr;
        rdy1 = (m_owner == 1) && fr;
        f0   = e0 && rdy0;
        f1   = e1 && rdy1;
        enq  = f0 || f1;
        chk("grant", W'(grant), W'(eg));
        chk("rdy0", W'(in0_enq__RDY), W'(rdy0));
        chk("rdy1", W'(in1_enq__RDY), W'(rdy1));
        chk("out_ena", W'(out_enq__ENA), W'(enq));
        chk("out_v", out_enq_v, (m_owner == 1) ? in1_enq_v : in0_enq_v);
        chk("occupancy", W'(occupancy), W'(m_occ));
        chk("deq_err", W'(deq_err), W'(m_err));
        if (rst) begin
            model_reset();
        end else begin
            if (d && m_occ == 0) m_err = 1;
            if (enq && !d) m_occ++;
            else if (d && !enq && m_occ > 0) m_occ--;
            if (m_owner < 0) begin
                if (r0 && r1) m_owner = 1 - m_last;
                else if (r0) m_owner = 0;
                else if (r1) m_owner = 1;
            end else begin
                me    = m_owner;
                rq_me = me ? r1 : r0;
                rq_ot = me ? r0 : r1;
                if (enq) m_beats++;
                if (!rq_me || m_beats == MB) begin
                    m_last  = me;
                    m_beats = 0;
                    m_owner = rq_ot ? 1 - me : (rq_me ? me : -1);
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1; in0_req = 0; in1_req = 0; in0_enq__ENA = 0; in1_enq__ENA = 0;
        in0_enq_v = '0; in1_enq_v = '0; out_enq__RDY = 0; deq_fire = 0;
        @(posedge CLK); #1;
        model_reset();
        cyc(1, 0, 0, 0, 0, 0, 0, 0);

        // single producer streaming; FIFO fills then drains one per cycle
        for (int c = 0; c < 6; c++) cyc(0, 1, 0, 1, 0, 1, 0, 0);
        for (int c = 0; c < 10; c++) cyc(0, 1, 0, 1, 0, 1, 1, 0);

        // contention from reset, dequeue every cycle
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 24; c++) cyc(0, 1, 1, 1, 1, 1, 1, 0);

        // stall after 2 beats of OWN0, then resume
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 1, 1, 0);
        cyc(0, 1, 0, 1, 0, 1, 1, 0);
        cyc(0, 1, 1, 1, 1, 1, 1, 0);
        for (int c = 0; c < 3; c++) cyc(0, 1, 1, 1, 1, 0, 1, 0);
        for (int c = 0; c < 6; c++) cyc(0, 1, 1, 1, 1, 1, 1, 0);

        // occupancy edges and sticky deq_err
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) cyc(0, 1, 0, 1, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, 1, 1, 0);
        for (int c = 0; c < 3; c++) cyc(0, 0, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 1);
        for (int c = 0; c < 3; c++) cyc(0, 0, 1, 0, 1, 1, 1, 0);
        chk("err_sticky", W'(deq_err), W'(1));
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("err_cleared", W'(deq_err), W'(0));

        // reset in the middle of an OWN1 burst, then a tie
        cyc(0, 0, 1, 0, 1, 1, 1, 0);
        cyc(0, 0, 1, 0, 1, 1, 1, 0);
        cyc(0, 0, 1, 0, 1, 1, 1, 0);
        cyc(1, 1, 1, 1, 1, 1, 1, 0);
        chk("rst_grant", W'(grant), W'(0));
        for (int c = 0; c < 3; c++) cyc(0, 1, 1, 1, 1, 1, 1, 0);

        // ENA from the non-owner is ignored
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) cyc(0, 1, 0, 0, 1, 1, 0, 0);

        // randomized traffic with occasional resets
        for (int c = 0; c < 2000; c++)
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
